// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a pending-write scoreboard.
// Optional forwarding compare port enabled by defining WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        wb_stall,
  output logic                        RegWrite,
  output logic [ADDR_W-1:0]           write_reg,
  output logic signed [DATA_W-1:0]    write_data,
  output logic [(1<<ADDR_W)-1:0]      pending
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]           fwd_reg,
  output logic                        fwd_valid,
  output logic signed [DATA_W-1:0]    fwd_data
`endif
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [PTR_W-1:0]          ptr, ptr_nxt;
  logic                      arb_en;
  logic                      accept_p0;
  logic [NUM_REQ-1:0]        grant_p0;
  logic [ADDR_W-1:0]         sel_reg_p0;
  logic signed [DATA_W-1:0]  sel_data_p0;
  logic [(1<<ADDR_W)-1:0]    pending_nxt;

  // Stage p0: two passes over the requesters emulate a search that starts at ptr and wraps.
  always_comb begin
    arb_en      = reset_n && (state != HOLD) && !wb_stall;
    accept_p0   = 1'b0;
    grant_p0    = '0;
    sel_reg_p0  = '0;
    sel_data_p0 = '0;
    ptr_nxt     = ptr;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_en && !accept_p0 && req_valid[i] &&
            ((p == 0) ? (i >= int'(ptr)) : (i < int'(ptr)))) begin
          accept_p0   = 1'b1;
          grant_p0[i] = 1'b1;
          sel_reg_p0  = req_reg[i*ADDR_W +: ADDR_W];
          sel_data_p0 = req_data[i*DATA_W +: DATA_W];
          ptr_nxt     = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  assign req_ready = grant_p0;

  always_comb begin
    state_nxt = state;
    RegWrite  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_p0) state_nxt = GRANT;
      end
      GRANT: begin
        RegWrite = !wb_stall;
        if (wb_stall)       state_nxt = HOLD;
        else if (accept_p0) state_nxt = GRANT;
        else                state_nxt = IDLE;
      end
      HOLD: begin
        if (!wb_stall) state_nxt = GRANT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A same-cycle retire and accept of one register leaves its bit set.
  always_comb begin
    pending_nxt = pending;
    if (RegWrite)  pending_nxt[write_reg]  = 1'b0;
    if (accept_p0) pending_nxt[sel_reg_p0] = 1'b1;
  end

  // Stage p1: registered write command and scoreboard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      write_reg  <= '0;
      write_data <= '0;
      pending    <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      pending <= pending_nxt;
      if (accept_p0) begin
        write_reg  <= sel_reg_p0;
        write_data <= sel_data_p0;
      end
    end
  end

`ifdef WB_FWD_EN
  always_comb begin
    fwd_valid = (state != IDLE) && (write_reg == fwd_reg);
    fwd_data  = fwd_valid ? write_data : '0;
  end
`endif

endmodule
